ldl_cdc_hs_tx: RTL and testbench

//  Source-domain endpoint of the two-phase (toggle) CDC handshake. It works on one clock.
//  - Takes words from an upstream valid/ready stream.
//  - Holds each word stable on tx_data and toggles tx_req.
//  - Waits for the far domain's toggled rx_ack, synchronised in here, before sending the next word.
//  - Sits in front of any toggle-handshake receiver in the far clock domain.

---
 rtl/ldl_cdc_hs_tx_if.sv | 32 +++
 rtl/ldl_cdc_hs_tx.sv | 129 ++++++++++++
 tb/tb_ldl_cdc_hs_tx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldl_cdc_hs_tx_if.sv
// Bus bundle for ldl_cdc_hs_tx: the upstream valid/ready stream, the toggle request/ack pair to
// the far domain, and the status outputs.
//   master : view of the source endpoint (ldl_cdc_hs_tx itself)
//   slave  : view of its surroundings (upstream producer, far-domain receiver, status observer)
// Signals:
//   din/din_vld/din_rdy  upstream stream
//   tx_req/tx_data       request toggle and held data towards the far domain
//   rx_ack               acknowledge toggle from the far domain (asynchronous)
//   busy/done_cnt        status
interface ldl_cdc_hs_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic             din_rdy;
  logic             tx_req;
  logic [WIDTH-1:0] tx_data;
  logic             rx_ack;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    input  din, din_vld, rx_ack,
    output din_rdy, tx_req, tx_data, busy, done_cnt
  );

  modport slave (
    output din, din_vld, rx_ack,
    input  din_rdy, tx_req, tx_data, busy, done_cnt
  );
endinterface

// File: rtl/ldl_cdc_hs_tx.sv
// Source-domain endpoint of a two-phase (toggle) CDC handshake, single clock.
// Accepts words from an upstream valid/ready stream into a one-entry staging buffer, launches
// each word by loading tx_data and toggling tx_req, and waits for the far domain to toggle rx_ack
// back (seen through a LEVEL-deep synchroniser) before launching the next one.
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   bus          ldl_cdc_hs_tx_if.master: din/din_vld/din_rdy, tx_req/tx_data, rx_ack,
//                busy, done_cnt
//   timeout_err  sticky "no ack within TIMEOUT WAIT cycles" flag; exists only when the macro
//                LDL_CDC_HS_TX_TIMEOUT_EN is defined
// Parameters: WIDTH data width, LEVEL synchroniser depth (>= 2), TIMEOUT wait limit (macro
// only), CNT_W done_cnt width.
module ldl_cdc_hs_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LEVEL   = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  ldl_cdc_hs_tx_if.master  bus
`ifdef LDL_CDC_HS_TX_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  logic [LEVEL-1:0] sync_q;
  logic             tx_req_q,   tx_req_d;
  logic [WIDTH-1:0] tx_data_q,  tx_data_d;
  logic             stg_vld_q,  stg_vld_d;
  logic [WIDTH-1:0] stg_data_q, stg_data_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic ack_s;
  logic in_wait;
  logic launch;
  logic accept;
  logic complete;
  logic din_rdy;

  assign ack_s   = sync_q[LEVEL-1];
  // The handshake state is implied by the toggle pair: unequal means a request is outstanding.
  assign in_wait = tx_req_q != ack_s;
  assign launch  = ~in_wait & stg_vld_q;
  assign din_rdy = ~stg_vld_q | launch;
  assign accept  = bus.din_vld & din_rdy;
  // ack_s is about to match tx_req: the synchroniser stage feeding it already does.
  assign complete = in_wait & (sync_q[LEVEL-2] == tx_req_q);

  always_comb begin
    tx_req_d   = tx_req_q;
    tx_data_d  = tx_data_q;
    stg_vld_d  = stg_vld_q;
    stg_data_d = stg_data_q;
    done_cnt_d = done_cnt_q;
    if (launch) begin
      tx_req_d  = ~tx_req_q;
      tx_data_d = stg_data_q;
      stg_vld_d = 1'b0;
    end
    // An accept on the launch edge refills the buffer the launch just emptied.
    if (accept) begin
      stg_vld_d  = 1'b1;
      stg_data_d = bus.din;
    end
    if (complete) begin
      done_cnt_d = done_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      done_cnt_q <= '0;
    end else begin
      sync_q     <= {sync_q[LEVEL-2:0], bus.rx_ack};
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      done_cnt_q <= done_cnt_d;
    end
  end

`ifdef LDL_CDC_HS_TX_TIMEOUT_EN
  localparam int unsigned WaitW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    if (launch) begin
      wait_cnt_d = '0;
    end else if (in_wait && (wait_cnt_q != WaitW'(TIMEOUT))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (in_wait && (wait_cnt_d == WaitW'(TIMEOUT))) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

  assign bus.din_rdy  = din_rdy;
  assign bus.tx_req   = tx_req_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = stg_vld_q | in_wait;
  assign bus.done_cnt = done_cnt_q;

endmodule

// File: tb/tb_ldl_cdc_hs_tx.sv
// Bench for ldl_cdc_hs_tx: WIDTH=8, LEVEL=2, CNT_W=4, TIMEOUT=10. Words are pushed to a
// scoreboard when accepted upstream and popped whenever tx_req toggles.
module tb_ldl_cdc_hs_tx;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned LEVEL   = 2;
  localparam int unsigned TIMEOUT = 10;
  localparam int unsigned CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic manual_ack = 1'b0;
  logic auto_ack = 1'b0;
  logic [2:0] echo_q;

  int n_cmp = 0;
  int n_err = 0;
  bit seen_low = 1'b0;

  logic [WIDTH-1:0] sb_q[$];
  logic             prev_req;
  logic [WIDTH-1:0] prev_data;

  ldl_cdc_hs_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

`ifdef LDL_CDC_HS_TX_TIMEOUT_EN
  logic timeout_err;
`endif

  ldl_cdc_hs_tx #(
    .WIDTH  (WIDTH),
    .LEVEL  (LEVEL),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master)
`ifdef LDL_CDC_HS_TX_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Far-side model: acknowledges each request toggle three cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) echo_q <= '0;
    else     echo_q <= {echo_q[1:0], bus.tx_req};
  end
  assign bus.rx_ack = auto_ack ? echo_q[2] : manual_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.tx_req !== prev_req) begin
        if (sb_q.size() == 0) check("tx_unexpected_launch", 32'd1, 32'd0);
        else check("sb_tx_data", 32'(bus.tx_data), 32'(sb_q.pop_front()));
      end else begin
        check("tx_data_hold", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.din_vld && bus.din_rdy) sb_q.push_back(bus.din);
    end
    prev_req  = bus.tx_req;
    prev_data = bus.tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a word and return right after the edge that accepts it; din_vld is left high.
  task automatic send_word(input logic [WIDTH-1:0] w);
    bit done = 1'b0;
    bus.din     = w;
    bus.din_vld = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.din_rdy) begin
        tick();
        done = 1'b1;
      end else begin
        seen_low = 1'b1;
      end
    end
    if (!done) check("send_word_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy; i++) tick();
    check("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset(input logic ack_during);
    rst        = 1'b1;
    manual_ack = ack_during;
    ticks(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{din: 8'h01, exp_data: 8'h01};
    vecs[1] = '{din: 8'h02, exp_data: 8'h02};
    vecs[2] = '{din: 8'h03, exp_data: 8'h03};
    vecs[3] = '{din: 8'hFF, exp_data: 8'hFF};
    vecs[4] = '{din: 8'h00, exp_data: 8'h00};
    vecs[5] = '{din: 8'h5A, exp_data: 8'h5A};

    bus.din     = '0;
    bus.din_vld = 1'b0;

    // Reset values, during and after reset.
    #3;
    check("rst_tx_req",   32'(bus.tx_req),   32'd0);
    check("rst_tx_data",  32'(bus.tx_data),  32'd0);
    check("rst_din_rdy",  32'(bus.din_rdy),  32'd1);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
    ticks(2);
    rst = 1'b0;
    tick();
    check("post_rst_din_rdy", 32'(bus.din_rdy), 32'd1);
    check("post_rst_busy",    32'(bus.busy),    32'd0);

    // Single word with manual ack.
    bus.din     = 8'hA5;
    bus.din_vld = 1'b1;
    tick();
    bus.din_vld = 1'b0;
    check("single_staged_busy", 32'(bus.busy),   32'd1);
    check("single_req_pre",     32'(bus.tx_req), 32'd0);
    tick();
    check("single_req",  32'(bus.tx_req),  32'd1);
    check("single_data", 32'(bus.tx_data), 32'hA5);
    ticks(4);
    check("single_hold_data", 32'(bus.tx_data),  32'hA5);
    check("single_hold_busy", 32'(bus.busy),     32'd1);
    check("single_hold_done", 32'(bus.done_cnt), 32'd0);
    manual_ack = 1'b1;
    tick();
    check("single_ack1_busy", 32'(bus.busy),     32'd1);
    check("single_ack1_done", 32'(bus.done_cnt), 32'd0);
    tick();
    check("single_ack2_busy", 32'(bus.busy),     32'd0);
    check("single_ack2_done", 32'(bus.done_cnt), 32'd1);

    // Table-driven stream with the echoing far side; din_vld held across words.
    auto_ack = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.din = vecs[i].din;
      send_word(vecs[i].din);
      if (i == 5) bus.din_vld = 1'b0;
    end
    wait_idle(200);
    ticks(2);
    check("stream_done_cnt", 32'(bus.done_cnt), 32'd7);
    check("stream_last_data", 32'(bus.tx_data), 32'(vecs[5].exp_data));
    check("stream_rdy_low_seen", 32'(seen_low), 32'd1);
    check("stream_sb_empty", 32'(sb_q.size()), 32'd0);

    // Launch and accept on the same edge.
    manual_ack = bus.tx_req;
    auto_ack   = 1'b0;
    tick();
    bus.din     = 8'h33;
    bus.din_vld = 1'b1;
    tick();
    bus.din = 8'h11;
    tick();
    bus.din = 8'h22;
    ticks(3);
    check("la_wait_data", 32'(bus.tx_data), 32'h33);
    check("la_wait_rdy",  32'(bus.din_rdy), 32'd0);
    manual_ack = ~manual_ack;
    ticks(2);
    check("la_cmp_data", 32'(bus.tx_data),  32'h33);
    check("la_cmp_done", 32'(bus.done_cnt), 32'd8);
    check("la_cmp_rdy",  32'(bus.din_rdy),  32'd1);
    tick();
    bus.din_vld = 1'b0;
    check("la_launch_data", 32'(bus.tx_data), 32'h11);
    check("la_launch_rdy",  32'(bus.din_rdy), 32'd0);
    check("la_launch_busy", 32'(bus.busy),    32'd1);
    manual_ack = ~manual_ack;
    ticks(3);
    check("la_second_data", 32'(bus.tx_data), 32'h22);
    manual_ack = ~manual_ack;
    ticks(2);
    check("la_idle_busy", 32'(bus.busy),     32'd0);
    check("la_idle_done", 32'(bus.done_cnt), 32'd10);

    // Reset in WAIT with the buffer full; far ack still high after reset.
    bus.din     = 8'h44;
    bus.din_vld = 1'b1;
    tick();
    bus.din = 8'h55;
    tick();
    bus.din_vld = 1'b0;
    tick();
    check("mw_data", 32'(bus.tx_data), 32'h44);
    check("mw_rdy",  32'(bus.din_rdy), 32'd0);
    rst        = 1'b1;
    manual_ack = 1'b1;
    #1;
    check("mw_rst_req",  32'(bus.tx_req),   32'd0);
    check("mw_rst_data", 32'(bus.tx_data),  32'd0);
    check("mw_rst_rdy",  32'(bus.din_rdy),  32'd1);
    check("mw_rst_busy", 32'(bus.busy),     32'd0);
    check("mw_rst_done", 32'(bus.done_cnt), 32'd0);
    tick();
    rst = 1'b0;
    ticks(LEVEL);
    check("stale_ack_busy", 32'(bus.busy),    32'd1);
    check("stale_ack_rdy",  32'(bus.din_rdy), 32'd1);
    manual_ack = 1'b0;
    ticks(LEVEL);
    check("stale_ack_clear_busy", 32'(bus.busy),     32'd0);
    check("stale_ack_clear_done", 32'(bus.done_cnt), 32'd1);

    // 17 transfers wrap a 4-bit done counter to 1.
    do_reset(1'b0);
    auto_ack = 1'b1;
    for (int i = 0; i < 17; i++) send_word(8'(8'h80 + i));
    bus.din_vld = 1'b0;
    wait_idle(600);
    ticks(2);
    check("wrap_done_cnt", 32'(bus.done_cnt), 32'd1);
    check("wrap_last_data", 32'(bus.tx_data), 32'h90);

`ifdef LDL_CDC_HS_TX_TIMEOUT_EN
    auto_ack = 1'b0;
    do_reset(1'b0);
    bus.din     = 8'h66;
    bus.din_vld = 1'b1;
    tick();
    bus.din_vld = 1'b0;
    tick();
    check("to_launch_err", 32'(timeout_err), 32'd0);
    ticks(TIMEOUT - 1);
    check("to_before_err", 32'(timeout_err), 32'd0);
    tick();
    check("to_at_err", 32'(timeout_err), 32'd1);
    manual_ack = 1'b1;
    ticks(LEVEL);
    check("to_late_done", 32'(bus.done_cnt), 32'd1);
    check("to_late_busy", 32'(bus.busy),     32'd0);
    check("to_sticky",    32'(timeout_err),  32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
